// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - b_in one bit per clock, LSB first, using one
// full-subtractor cell, with valid/ready handshakes on the operand and result sides.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;

    logic x, y, d_bit, br_nxt;

    always_comb begin
        x      = a_sh_q[0];
        y      = b_sh_q[0];
        d_bit  = x ^ y ^ br_q;
        br_nxt = (~x & y) | (~x & br_q) | (y & br_q);

        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = b_in;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Difference bits enter at the MSB so the final bit lands the word in place.
                res_d  = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = br_nxt;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
        end
    end

    // in_ready is gated by rst_n so it reads 0 while reset is held.
    assign in_ready  = rst_n & (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign diff      = res_q;
    assign b_out     = br_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor: the inverse-direction arithmetic unit that pairs with the team's ripple adders. It accepts two WIDTH-bit operands and a borrow-in through a valid/ready handshake and computes a - b - b_in one bit per clock, LSB first, using a single full-subtractor cell and shift registers. It returns the WIDTH-bit difference and borrow-out through a second valid/ready handshake. It is used where area matters more than latency, and as a self-check partner for the parallel adders (a + b then - b).

## Interface
- WIDTH, 4, operand and result width in bits; must be ≥ 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands on a/b/b_in are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- b_in  input  1  borrow-in.
- out_valid  output  1  diff/b_out are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  (a - b - b_in) mod 2^WIDTH.
- b_out  output  1  1 iff a < b + b_in (unsigned).

## Operation
- States: IDLE, RUN, DONE. Bit counter cnt, width clog2(WIDTH+1).
- IDLE: in_ready=1. When in_valid && in_ready, latch a and b into shift registers, load the borrow register from b_in, clear cnt, and go to RUN. Without in_valid, stay in IDLE.
- RUN: in_ready=0, out_valid=0. Each cycle, for the current LSBs x of a_sh and y of b_sh and the borrow register br:
  - d = x ^ y ^ br
  - br_next = (~x & y) | (~x & br) | (y & br)
  - Shift d into the MSB of the result register (right shift); shift a_sh and b_sh right; cnt++.
  - When cnt reaches WIDTH-1 during a cycle, that cycle processes the last bit and the next state is DONE.
- DONE: out_valid=1, diff = result register, b_out = br. Outputs are held stable while out_ready=0. When out_valid && out_ready, go to IDLE.
- in_valid is ignored outside IDLE; operands are never re-sampled mid-operation.
- No overlap: a new operation is accepted no earlier than the cycle after the output handshake.
- Arithmetic: the result equals {b_out, diff} = {1'b0, a} - {1'b0, b} - b_in, taken as a (WIDTH+1)-bit two's complement with wrap-around. For example, 0 - 0 - 1 gives diff = all ones and b_out = 1.

## Timing
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - in_ready = 1 as soon as reset deasserts; during reset in_ready = 0.
  - out_valid = 0; diff = 0; b_out = 0.
  - cnt, shift registers and borrow register are all cleared.
- Reset asserted mid-RUN or in DONE aborts the operation immediately. No result is produced, and the block is in IDLE after release.
- Latency:
  - Input handshake at edge E0.
  - RUN occupies the WIDTH cycles following E0.
  - out_valid rises after edge E0+WIDTH, i.e. WIDTH+1 cycles from acceptance to first out_valid.
- Throughput: one result per WIDTH+2 cycles when out_ready is held at 1. Breakdown: the accept cycle, WIDTH RUN cycles, one DONE cycle, then IDLE.
- Output handshake at edge Ed: out_valid falls and in_ready rises after Ed. The next in_valid is sampled at edge Ed+1.
- WIDTH=1: RUN lasts exactly one cycle.
- in_valid and in_ready are never both high together with out_valid; the states are mutually exclusive.

## Test plan
- WIDTH=4, a=9, b=3, b_in=0 → diff=6, b_out=0. out_valid first seen 5 cycles after the accept edge; in_ready low throughout.
- a=3, b=9, b_in=0 → diff=4'hA, b_out=1. Also a=0, b=0, b_in=1 → diff=4'hF, b_out=1. Also a=15, b=15, b_in=0 → diff=0, b_out=0.
- Backpressure: hold out_ready=0 for 6 cycles in DONE while toggling in_valid with new operands. diff/b_out stay stable, in_ready stays 0, and the new operands are not accepted. After out_ready=1, the block returns to IDLE and in_ready=1.
- Reset mid-operation: assert rst_n=0 asynchronously two cycles into RUN (between clock edges). Outputs clear immediately. After release, in_ready=1 and out_valid never pulses for the aborted operation.
- Exhaustive sweep, WIDTH=4: all 512 (a, b, b_in) combinations, with random in_valid/out_ready stalls. Every result must match the (WIDTH+1)-bit reference subtraction, exactly one result per accepted input, in order. Also check that feeding diff + b + b_in through the parallel adder reproduces a, with carry = b_out.
- Back-to-back: in_valid and out_ready held at 1 → accepts spaced exactly WIDTH+2 cycles apart. Repeat at WIDTH=1 (a=0, b=1 → diff=1, b_out=1) and WIDTH=8 (a=8'h00, b=8'h01, b_in=0 → diff=8'hFF, b_out=1).
